clock_setup_ctrl: RTL and testbench

Setup-mode sequencer for the clock/calendar datapath. Converts three debounced push-button levels into the `display`, per-field active-low `setup_*` selects, `tick` and `inc_dec_*` controls consumed by the minute, hour, day, month and year counters. Walks the user through the fields in a fixed order, auto-repeats held buttons, and returns to normal run mode on an inactivity timeout.

---
 rtl/clock_setup_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_clock_setup_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_setup_ctrl
//  Description : Setup-mode sequencer for the clock/calendar datapath. Turns
//                debounced mode/up/down button levels into field selects,
//                adjust strobes with auto-repeat, a blink enable and an
//                inactivity timeout back to run mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_setup_ctrl #(
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 100,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       tick_ms,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       display,
    output logic       setup_year,
    output logic       setup_month,
    output logic       setup_day,
    output logic       setup_hour,
    output logic       setup_min,
    output logic       tick,
    output logic       inc_dec,
    output logic [2:0] field,
    output logic       blink
);

    localparam int RPT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_MS + 1);
    localparam int BW      = $clog2(BLINK_MS + 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        S_YEAR  = 3'd1,
        S_MONTH = 3'd2,
        S_DAY   = 3'd3,
        S_HOUR  = 3'd4,
        S_MIN   = 3'd5
    } state_t;

    typedef enum logic {
        RPT_HOLD   = 1'b0,
        RPT_REPEAT = 1'b1
    } rpt_t;

    state_t        st_q, st_d;
    rpt_t          rpt_mode_q, rpt_mode_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d, blk_inc;
    logic [BW-1:0] force_q, force_d;
    logic          phase_q, phase_d;
    logic          mode_prev_q, up_prev_q, dn_prev_q;

    logic          display_q, display_d;
    logic [4:0]    setup_q, setup_d;     // {year, month, day, hour, min}
    logic          tick_q, tick_d;
    logic          inc_q, inc_d;
    logic          blink_q, blink_d;

    logic          mode_rise, up_rise, dn_rise, any_rise, timeout;

    assign mode_rise = btn_mode & ~mode_prev_q;
    assign up_rise   = btn_up   & ~up_prev_q;
    assign dn_rise   = btn_down & ~dn_prev_q;
    assign any_rise  = mode_rise | up_rise | dn_rise;

    assign rpt_inc = (rpt_cnt_q == {RW{1'b1}}) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
    assign blk_inc = (blk_cnt_q == {BW{1'b1}}) ? blk_cnt_q : blk_cnt_q + 1'b1;

    // Next-state, counter and output decode for the whole sequencer
    always_comb begin
        st_d       = st_q;
        rpt_mode_d = rpt_mode_q;
        rpt_cnt_d  = rpt_cnt_q;
        to_cnt_d   = to_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        force_d    = force_q;
        phase_d    = phase_q;
        tick_d     = 1'b0;
        inc_d      = inc_q;
        timeout    = 1'b0;

        if (st_q == RUN) begin
            // Adjust buttons are ignored in run mode
            if (mode_rise) begin
                st_d = S_YEAR;
            end
        end else begin
            // Inactivity timer: only edges restart it, held levels do not
            if (any_rise) begin
                to_cnt_d = '0;
            end else if (tick_ms) begin
                to_cnt_d = (to_cnt_q == {TW{1'b1}}) ? to_cnt_q : to_cnt_q + 1'b1;
            end
            timeout = (to_cnt_d >= TW'(TIMEOUT_MS));

            // Free-running blink phase plus the post-adjust hold-on window
            if (tick_ms) begin
                if (blk_inc >= BW'(BLINK_MS)) begin
                    blk_cnt_d = '0;
                    phase_d   = ~phase_q;
                end else begin
                    blk_cnt_d = blk_inc;
                end
                if (force_q != '0) begin
                    force_d = force_q - 1'b1;
                end
            end

            if (mode_rise) begin
                // Mode edge wins over any adjust activity in the same cycle
                case (st_q)
                    S_YEAR:  st_d = S_MONTH;
                    S_MONTH: st_d = S_DAY;
                    S_DAY:   st_d = S_HOUR;
                    S_HOUR:  st_d = S_MIN;
                    default: st_d = RUN;
                endcase
                rpt_cnt_d  = '0;
                rpt_mode_d = RPT_HOLD;
            end else if (timeout) begin
                st_d       = RUN;
                rpt_cnt_d  = '0;
                rpt_mode_d = RPT_HOLD;
            end else if (btn_up && btn_down) begin
                rpt_cnt_d  = '0;
                rpt_mode_d = RPT_HOLD;
            end else if (up_rise || dn_rise) begin
                tick_d     = 1'b1;
                inc_d      = up_rise;
                rpt_cnt_d  = '0;
                rpt_mode_d = RPT_HOLD;
            end else if (btn_up || btn_down) begin
                if (tick_ms) begin
                    if (rpt_mode_q == RPT_HOLD && rpt_inc >= RW'(HOLD_MS)) begin
                        tick_d     = 1'b1;
                        inc_d      = btn_up;
                        rpt_cnt_d  = '0;
                        rpt_mode_d = RPT_REPEAT;
                    end else if (rpt_mode_q == RPT_REPEAT && rpt_inc >= RW'(REPEAT_MS)) begin
                        tick_d     = 1'b1;
                        inc_d      = btn_up;
                        rpt_cnt_d  = '0;
                    end else begin
                        rpt_cnt_d  = rpt_inc;
                    end
                end
            end else begin
                rpt_cnt_d  = '0;
                rpt_mode_d = RPT_HOLD;
            end

            if (tick_d) begin
                force_d = BW'(BLINK_MS);
            end
        end

        // Leaving (or staying in) run mode parks every timer
        if (st_d == RUN) begin
            rpt_cnt_d  = '0;
            rpt_mode_d = RPT_HOLD;
            to_cnt_d   = '0;
            blk_cnt_d  = '0;
            force_d    = '0;
            phase_d    = 1'b0;
        end

        display_d = (st_d != RUN);
        blink_d   = (st_d != RUN) && (phase_d || (force_d != '0));
        case (st_d)
            S_YEAR:  setup_d = 5'b01111;
            S_MONTH: setup_d = 5'b10111;
            S_DAY:   setup_d = 5'b11011;
            S_HOUR:  setup_d = 5'b11101;
            S_MIN:   setup_d = 5'b11110;
            default: setup_d = 5'b11111;
        endcase
    end

    // State, counters, edge-detect history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= RUN;
            rpt_mode_q  <= RPT_HOLD;
            rpt_cnt_q   <= '0;
            to_cnt_q    <= '0;
            blk_cnt_q   <= '0;
            force_q     <= '0;
            phase_q     <= 1'b0;
            mode_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            dn_prev_q   <= 1'b0;
            display_q   <= 1'b0;
            setup_q     <= 5'b11111;
            tick_q      <= 1'b0;
            inc_q       <= 1'b1;
            blink_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            rpt_mode_q  <= rpt_mode_d;
            rpt_cnt_q   <= rpt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            force_q     <= force_d;
            phase_q     <= phase_d;
            mode_prev_q <= btn_mode;
            up_prev_q   <= btn_up;
            dn_prev_q   <= btn_down;
            display_q   <= display_d;
            setup_q     <= setup_d;
            tick_q      <= tick_d;
            inc_q       <= inc_d;
            blink_q     <= blink_d;
        end
    end

    assign display     = display_q;
    assign setup_year  = setup_q[4];
    assign setup_month = setup_q[3];
    assign setup_day   = setup_q[2];
    assign setup_hour  = setup_q[1];
    assign setup_min   = setup_q[0];
    assign tick        = tick_q;
    assign inc_dec     = inc_q;
    assign field       = st_q;
    assign blink       = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_setup_ctrl
//  Description : Directed self-checking bench for clock_setup_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_setup_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_ms = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       display;
    logic       setup_year, setup_month, setup_day, setup_hour, setup_min;
    logic       tick;
    logic       inc_dec;
    logic [2:0] field;
    logic       blink;

    int total = 0;
    int bad   = 0;
    int tcnt  = 0;
    int snap;

    logic [4:0] sel;
    logic [4:0] exp_sel [0:5];

    assign sel = {setup_year, setup_month, setup_day, setup_hour, setup_min};

    clock_setup_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_ms     (tick_ms),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .display     (display),
        .setup_year  (setup_year),
        .setup_month (setup_month),
        .setup_day   (setup_day),
        .setup_hour  (setup_hour),
        .setup_min   (setup_min),
        .tick        (tick),
        .inc_dec     (inc_dec),
        .field       (field),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    // Count adjust strobes as seen just before each rising edge
    always @(posedge clk) begin
        if (tick === 1'b1) tcnt <= tcnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press_mode();
        @(negedge clk) btn_mode = 1'b1;
        @(negedge clk) btn_mode = 1'b0;
    endtask

    task automatic ms(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_ms = 1'b1;
            @(negedge clk) tick_ms = 1'b0;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_sel[0] = 5'b11111;
        exp_sel[1] = 5'b01111;
        exp_sel[2] = 5'b10111;
        exp_sel[3] = 5'b11011;
        exp_sel[4] = 5'b11101;
        exp_sel[5] = 5'b11110;

        // Reset values
        cyc(3);
        chk("rst_field", field, 0);
        chk("rst_display", display, 0);
        chk("rst_sel", sel, 5'b11111);
        chk("rst_tick", tick, 0);
        chk("rst_incdec", inc_dec, 1);
        chk("rst_blink", blink, 0);
        @(negedge clk) rst = 1'b1;
        cyc(2);

        // Field walk, first press holds mode for several cycles
        snap = tcnt;
        @(negedge clk) btn_mode = 1'b1;
        cyc(4);
        btn_mode = 1'b0;
        chk("walk_field1", field, 1);
        chk("walk_sel1", sel, exp_sel[1]);
        chk("walk_disp1", display, 1);
        for (int i = 2; i <= 5; i++) begin
            press_mode();
            chk("walk_field", field, i);
            chk("walk_sel", sel, exp_sel[i]);
        end
        press_mode();
        chk("walk_field0", field, 0);
        chk("walk_disp0", display, 0);
        chk("walk_sel0", sel, 5'b11111);
        cyc(1);
        chk("walk_noticks", tcnt - snap, 0);

        // Single up and down pulses in S_DAY
        press_mode(); press_mode(); press_mode();
        chk("day_field", field, 3);
        snap = tcnt;
        @(negedge clk) btn_up = 1'b1;
        @(negedge clk);
        chk("up_tick", tick, 1);
        chk("up_inc", inc_dec, 1);
        chk("up_blink", blink, 1);
        @(negedge clk);
        chk("up_tick_off", tick, 0);
        @(negedge clk) btn_up = 1'b0;
        cyc(2);
        chk("up_count", tcnt - snap, 1);
        @(negedge clk) btn_down = 1'b1;
        @(negedge clk);
        chk("dn_tick", tick, 1);
        chk("dn_inc", inc_dec, 0);
        cyc(2);
        btn_down = 1'b0;
        cyc(2);
        chk("dn_count", tcnt - snap, 2);

        // Auto-repeat in S_HOUR
        press_mode();
        chk("hour_field", field, 4);
        snap = tcnt;
        @(negedge clk) btn_up = 1'b1;
        ms(499);
        cyc(1);
        chk("rpt_499", tcnt - snap, 1);
        ms(1);
        cyc(1);
        chk("rpt_500", tcnt - snap, 2);
        ms(500);
        cyc(1);
        chk("rpt_1000", tcnt - snap, 7);
        chk("rpt_inc", inc_dec, 1);
        @(negedge clk) btn_up = 1'b0;
        cyc(2);

        // Both adjust buttons rising together
        snap = tcnt;
        @(negedge clk) begin btn_up = 1'b1; btn_down = 1'b1; end
        cyc(3);
        btn_up = 1'b0; btn_down = 1'b0;
        cyc(2);
        chk("both_noticks", tcnt - snap, 0);

        // Mode and up together in S_YEAR
        press_mode(); press_mode(); press_mode();
        chk("year_field", field, 1);
        snap = tcnt;
        @(negedge clk) begin btn_mode = 1'b1; btn_up = 1'b1; end
        @(negedge clk);
        chk("modeup_field", field, 2);
        chk("modeup_tick", tick, 0);
        btn_mode = 1'b0; btn_up = 1'b0;
        cyc(2);
        chk("modeup_noticks", tcnt - snap, 0);

        // Asynchronous reset in the middle of a repeat in S_MONTH
        @(negedge clk) btn_up = 1'b1;
        ms(650);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_field", field, 0);
        chk("arst_display", display, 0);
        chk("arst_sel", sel, 5'b11111);
        chk("arst_tick", tick, 0);
        chk("arst_incdec", inc_dec, 1);
        chk("arst_blink", blink, 0);
        @(negedge clk) rst = 1'b1;
        snap = tcnt;
        ms(600);
        cyc(1);
        chk("arst_noticks", tcnt - snap, 0);
        chk("arst_stay_run", field, 0);
        @(negedge clk) btn_up = 1'b0;
        cyc(2);

        // Blink phase and inactivity timeout in S_MIN
        for (int i = 0; i < 5; i++) press_mode();
        chk("min_field", field, 5);
        chk("min_blink0", blink, 0);
        ms(249);
        chk("blink_249", blink, 0);
        ms(1);
        chk("blink_250", blink, 1);
        ms(9749);
        chk("to_9999", field, 5);
        @(negedge clk) btn_up = 1'b1;
        @(negedge clk) btn_up = 1'b0;
        ms(9999);
        chk("to_restart", field, 5);
        chk("to_restart_disp", display, 1);
        snap = tcnt;
        ms(1);
        chk("to_field", field, 0);
        chk("to_display", display, 0);
        chk("to_sel", sel, 5'b11111);
        chk("to_blink", blink, 0);
        cyc(1);
        chk("to_noticks", tcnt - snap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
